// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared addresses, source indices, FSM states and vector helper
package interrupt_controller_pkg;

   localparam logic [15:0] IF_ADDR = 16'hFF0F;
   localparam logic [15:0] IE_ADDR = 16'hFFFF;

   localparam int INT_VBLANK = 0;
   localparam int INT_STAT   = 1;
   localparam int INT_TIMER  = 2;
   localparam int INT_SERIAL = 3;
   localparam int INT_JOYPAD = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK
   } int_state_e;

   function automatic logic [7:0] vector_of(input logic [7:0] base, input int stride, input int idx);
      return 8'(int'(base) + idx * stride);
   endfunction

endpackage

// File: rtl/int_priority_encoder.sv
// rtl/int_priority_encoder.sv - lowest-set-bit index with valid flag
module int_priority_encoder #(
   parameter int NUM_SRC = 5,
   parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - IF/IE registers, prioritised CPU request and per-source acknowledge
// Optional: INT_WAKE_OUTPUT_EN adds a registered wake output equal to |(IF & IE).
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int          NUM_SRC       = 5,
   parameter logic [7:0]  VECTOR_BASE   = 8'h40,
   parameter int          VECTOR_STRIDE = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_req,
   output logic [NUM_SRC-1:0] src_ack,
   output logic               cpu_irq,
   output logic [7:0]         cpu_vector,
   input  logic               cpu_ack,
`ifdef INT_WAKE_OUTPUT_EN
   output logic               wake,
`endif
   input  logic [15:0]        A,
   input  logic [7:0]         Di,
   output logic [7:0]         Do,
   input  logic               wr_n,
   input  logic               rd_n,
   input  logic               cs
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   if (int'(VECTOR_BASE) + (NUM_SRC - 1) * VECTOR_STRIDE > 255) begin : g_bad_vector
      $error("interrupt_controller: highest vector does not fit in 8 bits");
   end
   if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
      $error("interrupt_controller: NUM_SRC must be 1..8");
   end

   logic [NUM_SRC-1:0] if_reg, ie_reg, src_req_d;
   logic [NUM_SRC-1:0] rise, svc_clr, if_nxt, pending, di_src;
   logic [NUM_SRC-1:0] ack_nxt;
   logic [IDX_W-1:0]   win_idx, win_nxt, enc_idx;
   logic               enc_valid, irq_nxt, wr_if_hit, wr_ie_hit, rd_hit, withdraw;
   logic [7:0]         vec_nxt, rd_if, rd_ie;
   logic               unused_di;
   int_state_e         state, state_nxt;

   assign di_src    = Di[NUM_SRC-1:0];
   assign unused_di = &Di;
   assign wr_if_hit = cs & ~wr_n & (A == IF_ADDR);
   assign wr_ie_hit = cs & ~wr_n & (A == IE_ADDR);
   assign rd_hit    = cs & wr_n & ~rd_n;
   assign rise      = src_req & ~src_req_d;
   assign pending   = if_reg & ie_reg;

   // Edge set beats service clear, which beats a CPU write, bit by bit.
   assign if_nxt = rise | (~svc_clr & (wr_if_hit ? di_src : if_reg));

   // A CPU write that clears the in-flight source's IF or IE bit cancels the request.
   assign withdraw = (wr_if_hit | wr_ie_hit) & ~di_src[win_idx];

   always_comb begin
      rd_if = 8'hFF;
      rd_if[NUM_SRC-1:0] = if_reg;
      rd_ie = 8'h00;
      rd_ie[NUM_SRC-1:0] = ie_reg;
   end

   int_priority_encoder #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_enc (
      .req   (pending),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      state_nxt = state;
      irq_nxt   = cpu_irq;
      vec_nxt   = cpu_vector;
      win_nxt   = win_idx;
      ack_nxt   = '0;
      svc_clr   = '0;
      case (state)
         IDLE: begin
            if (enc_valid) begin
               win_nxt   = enc_idx;
               vec_nxt   = vector_of(VECTOR_BASE, VECTOR_STRIDE, int'(enc_idx));
               irq_nxt   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (cpu_ack) begin
               irq_nxt          = 1'b0;
               svc_clr[win_idx] = 1'b1;
               ack_nxt[win_idx] = 1'b1;
               state_nxt        = ACK;
            end else if (withdraw) begin
               irq_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         ACK: begin
            if (!cpu_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         win_idx    <= '0;
         cpu_irq    <= 1'b0;
         cpu_vector <= 8'h00;
         src_ack    <= '0;
      end else begin
         state      <= state_nxt;
         win_idx    <= win_nxt;
         cpu_irq    <= irq_nxt;
         cpu_vector <= vec_nxt;
         src_ack    <= ack_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         if_reg    <= '0;
         ie_reg    <= '0;
         src_req_d <= '0;
         Do        <= 8'h00;
      end else begin
         src_req_d <= src_req;
         if_reg    <= if_nxt;
         if (wr_ie_hit) ie_reg <= di_src;
         if (rd_hit) begin
            if (A == IF_ADDR)      Do <= rd_if;
            else if (A == IE_ADDR) Do <= rd_ie;
         end
      end
   end

`ifdef INT_WAKE_OUTPUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) wake <= 1'b0;
      else       wake <= |pending;
   end
`endif

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Central interrupt arbiter for the Game Boy core.
- Collects level requests from the timer, vblank, LCD STAT, serial and joypad blocks.
- Holds the IF (FF0F) and IE (FFFF) registers and presents one prioritised request plus its vector to the CPU.
- On CPU acknowledge, pulses the per-source acknowledge so the originating peripheral drops its request.

Parameters:
- NUM_SRC, 5, number of interrupt sources; bit 0 has the highest priority.
- VECTOR_BASE, 8'h40, vector of source 0.
- VECTOR_STRIDE, 8, vector spacing between consecutive sources.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- src_req  in  NUM_SRC  level requests from peripherals; each is held until its src_ack
- src_ack  out  NUM_SRC  one-cycle one-hot acknowledge pulse to the serviced source
- cpu_irq  out  1  interrupt request to the CPU
- cpu_vector  out  8  vector of the latched interrupt
- cpu_ack  in  1  CPU accepted the interrupt; level held for at least 1 cycle
- A  in  16  CPU address
- Di  in  8  write data
- Do  out  8  registered read data
- wr_n  in  1  active-low write strobe
- rd_n  in  1  active-low read strobe
- cs  in  1  chip select

Behaviour:
- Reset (asynchronous) clears: IF, IE, src_req_d, cpu_irq, cpu_vector, src_ack, Do, state=IDLE.
- Edge capture: src_req_d <= src_req every cycle. A rising edge (src_req & ~src_req_d) sets the matching IF bit next cycle.
- Register write (cs & !wr_n):
  - FF0F: IF <= Di[NUM_SRC-1:0].
  - FFFF: IE <= Di[NUM_SRC-1:0].
  - Other addresses are ignored.
- Register read (cs & wr_n & !rd_n): Do registered, 1-cycle latency.
  - FF0F returns {3'b111, IF}; FFFF returns {3'b000, IE}.
  - Other addresses leave Do unchanged.
- IF update priority for one bit in the same cycle, highest first: edge set > service clear > CPU write. A new edge is never lost.
- pending = IF & IE. winner = lowest-index set bit of pending.
- FSM:
  - IDLE: if pending != 0, latch win_idx; cpu_vector <= VECTOR_BASE + win_idx*VECTOR_STRIDE; cpu_irq <= 1; go to REQ.
  - REQ: hold cpu_vector stable; higher-priority arrivals do not preempt. On cpu_ack: cpu_irq <= 0, clear IF[win_idx], src_ack[win_idx] <= 1 for exactly one cycle; go to ACK.
  - ACK: src_ack <= 0. Wait for cpu_ack low, then go to IDLE.
  - REQ withdrawal: if IF[win_idx] or IE[win_idx] is cleared by a CPU write while in REQ and cpu_ack is low, drop cpu_irq, no src_ack, go to IDLE. Re-arbitration happens the next cycle.
- Minimum spacing between two serviced interrupts: 3 cycles (REQ, ACK, IDLE).
- Vector width: 8-bit sum; the parameters must keep it below 256 (checked at elaboration).
- cpu_ack in IDLE or ACK is ignored.

Optional Feature:
- Macro INT_WAKE_OUTPUT_EN.
- Defined: adds output port wake (1 bit), registered, equal to |(IF & IE). It is independent of FSM state and is used to release CPU HALT/STOP. Reset value 0.
- Undefined: no wake port; no extra logic.

Decomposition:
- Shared package/include:
  - IF_ADDR=16'hFF0F, IE_ADDR=16'hFFFF
  - source index constants: INT_VBLANK=0, INT_STAT=1, INT_TIMER=2, INT_SERIAL=3, INT_JOYPAD=4
  - FSM state encoding: IDLE, REQ, ACK
- One sub-module, int_priority_encoder: combinational, outputs lowest-set-bit index plus a valid flag. It is parameterised by NUM_SRC.

Test Plan:
- Reset mid-REQ with cpu_irq=1 → all outputs 0 immediately, state IDLE, IF/IE read back 8'hE0/8'h00.
- IE=8'h04, pulse src_req[2] high and hold → IF reads 8'hE4, cpu_irq=1, cpu_vector=8'h50. Then cpu_ack for 2 cycles → src_ack=5'b00100 for one cycle, IF reads 8'hE0, cpu_irq=0.
- IE=8'h1F; src_req[4] and src_req[0] rise in the same cycle → cpu_vector=8'h40. After ack → second request with cpu_vector=8'h60.
- In REQ with vector 8'h58, raise src_req[0] → vector stays 8'h58 until serviced, then 8'h40 is issued.
- In REQ for source 2, write FF0F=8'h00 → cpu_irq drops, no src_ack. In the same cycle as that write, a src_req[2] edge → IF[2] stays 1 and cpu_irq re-asserts.
- INT_WAKE_OUTPUT_EN defined, IE=8'h01, src_req[0] rises → wake=1 two cycles later; cleared after service.
